// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four
// little-endian byte reads and presents it to IF/ID with stall and redirect handling.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    localparam logic [1:0] FETCH     = 2'd0;
    localparam logic [1:0] WAIT_LAST = 2'd1;
    localparam logic [1:0] OUT       = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        req_cnt;
    logic              pend;
    logic [1:0]        pend_idx;
    logic [23:0]       asm_buf;
    logic              accept;

    // A redirect suppresses the request in the same cycle so no stale byte is fetched.
    assign mem_rd_o   = !rst && !br_taken_i && (state == FETCH);
    assign mem_addr_o = pc + ADDR_W'(req_cnt);
    assign accept     = mem_rd_o && !mem_busy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            req_cnt    <= 2'd0;
            pend       <= 1'b0;
            pend_idx   <= 2'd0;
            asm_buf    <= '0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
            if_valid_o <= 1'b0;
        end else if (br_taken_i) begin
            pc         <= br_target_i;
            state      <= FETCH;
            req_cnt    <= 2'd0;
            pend       <= 1'b0;
            if_valid_o <= 1'b0;
        end else begin
            pend <= accept;
            if (accept)
                pend_idx <= req_cnt;

            // Byte 3 is never buffered: it is consumed straight off the bus in WAIT_LAST.
            if (pend) begin
                case (pend_idx)
                    2'd0:    asm_buf[7:0]   <= mem_rdata_i;
                    2'd1:    asm_buf[15:8]  <= mem_rdata_i;
                    2'd2:    asm_buf[23:16] <= mem_rdata_i;
                    default: ;
                endcase
            end

            case (state)
                FETCH: begin
                    if (accept) begin
                        req_cnt <= req_cnt + 2'd1;
                        if (req_cnt == 2'd3)
                            state <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if_inst_o  <= {mem_rdata_i, asm_buf};
                    if_pc_o    <= pc;
                    if_valid_o <= 1'b1;
                    pc         <= pc + ADDR_W'(4);
                    state      <= OUT;
                end
                OUT: begin
                    if (!stall_i) begin
                        if_valid_o <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, br, busy;
    logic [31:0] tgt;
    logic [7:0]  rdata;
    logic        mem_rd, valid;
    logic [31:0] addr, pc_out, inst;

    int tests = 0;
    int fails = 0;

    if_fetch dut (
        .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
        .mem_busy_i(busy), .mem_rdata_i(rdata), .mem_rd_o(mem_rd), .mem_addr_o(addr),
        .if_pc_o(pc_out), .if_inst_o(inst), .if_valid_o(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic set_in(input logic r, input logic b, input logic s, input logic t, input logic [31:0] g);
        rst = r; busy = b; stall = s; br = t; tgt = g;
        #1;
    endtask

    // Memory model: an accepted request returns its byte next cycle, otherwise garbage.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = mem_rd && !busy;
        a   = addr;
        @(posedge clk);
        #1;
        rdata = acc ? mem_byte(a) : 8'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0);
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL rst_rd: got %b want 0", mem_rd); end
        tick();
        tick();
        set_in(0, 0, 0, 0, 0);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", pc_out); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst: got %h want 0", inst); end
        tests++; if (mem_rd !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL rst_req: got rd=%b addr=%h want rd=1 addr=0", mem_rd, addr); end
    endtask

    task automatic test_basic();
        for (int c = 0; c <= 6; c++) begin
            set_in(0, 0, 0, 0, 0);
            if (c < 4) begin
                tests++; if (mem_rd !== 1'b1 || addr !== 32'(c)) begin fails++; $display("FAIL basic_addr c%0d: got rd=%b addr=%h want addr=%h", c, mem_rd, addr, c); end
            end
            if (c == 4) begin
                tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL basic_wait_rd: got %b want 0", mem_rd); end
            end
            if (c < 6) begin
                tests++; if (valid !== (c == 5)) begin fails++; $display("FAIL basic_valid c%0d: got %b want %b", c, valid, c == 5); end
            end
            if (c == 5) begin
                tests++; if (pc_out !== 32'h0 || inst !== 32'h00100513) begin fails++; $display("FAIL basic_out: got pc=%h inst=%h want pc=0 inst=00100513", pc_out, inst); end
            end
            if (c == 6) begin
                tests++; if (mem_rd !== 1'b1 || addr !== 32'h4) begin fails++; $display("FAIL basic_next: got rd=%b addr=%h want addr=4", mem_rd, addr); end
            end
            if (c < 6) tick();
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c <= 10; c++) begin
            set_in(0, 0, (c >= 5 && c <= 8), 0, 0);
            if (c < 4) begin
                tests++; if (mem_rd !== 1'b1 || addr !== 32'(4 + c)) begin fails++; $display("FAIL stall_addr c%0d: got %h want %h", c, addr, 4 + c); end
            end
            if (c >= 4 && c <= 9) begin
                tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL stall_rd c%0d: got %b want 0", c, mem_rd); end
            end
            if (c >= 5 && c <= 9) begin
                tests++; if (valid !== 1'b1 || pc_out !== 32'h4 || inst !== word(4)) begin fails++; $display("FAIL stall_hold c%0d: got v=%b pc=%h inst=%h want v=1 pc=4 inst=%h", c, valid, pc_out, inst, word(4)); end
            end
            if (c == 10) begin
                tests++; if (valid !== 1'b0 || mem_rd !== 1'b1 || addr !== 32'h8) begin fails++; $display("FAIL stall_resume: got v=%b rd=%b addr=%h want v=0 rd=1 addr=8", valid, mem_rd, addr); end
            end
            if (c < 10) tick();
        end
    endtask

    task automatic test_busy();
        logic [31:0] ea [0:5];
        ea = '{32'h8, 32'h9, 32'h9, 32'h9, 32'hA, 32'hB};
        for (int c = 0; c <= 8; c++) begin
            set_in(0, (c == 1 || c == 2), 0, 0, 0);
            if (c < 6) begin
                tests++; if (mem_rd !== 1'b1 || addr !== ea[c]) begin fails++; $display("FAIL busy_addr c%0d: got %h want %h", c, addr, ea[c]); end
            end
            if (c < 8) begin
                tests++; if (valid !== (c == 7)) begin fails++; $display("FAIL busy_valid c%0d: got %b want %b", c, valid, c == 7); end
            end
            if (c == 7) begin
                tests++; if (pc_out !== 32'h8 || inst !== word(8)) begin fails++; $display("FAIL busy_out: got pc=%h inst=%h want pc=8 inst=%h", pc_out, inst, word(8)); end
            end
            if (c == 8) begin
                tests++; if (addr !== 32'hC) begin fails++; $display("FAIL busy_next: got %h want c", addr); end
            end
            if (c < 8) tick();
        end
    endtask

    // Runs a clean fetch from the current pc and checks its delivery; ends in the OUT cycle.
    task automatic run_fetch(input logic [31:0] p, input string nm);
        for (int c = 0; c <= 5; c++) begin
            set_in(0, 0, 0, 0, 0);
            if (c < 4) begin
                tests++; if (mem_rd !== 1'b1 || addr !== p + 32'(c)) begin fails++; $display("FAIL %s_addr c%0d: got %h want %h", nm, c, addr, p + 32'(c)); end
            end
            if (c < 5) tick();
        end
        tests++; if (valid !== 1'b1 || pc_out !== p || inst !== word(p)) begin fails++; $display("FAIL %s_out: got v=%b pc=%h inst=%h want pc=%h inst=%h", nm, valid, pc_out, inst, p, word(p)); end
    endtask

    task automatic test_redirect();
        run_fetch(32'hC, "pre");
        tick();
        set_in(0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 32'h100);
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL br_rd: got %b want 0", mem_rd); end
        tick();
        run_fetch(32'h100, "br");
    endtask

    task automatic test_redirect_stall();
        set_in(0, 0, 1, 1, 32'h200);
        tick();
        set_in(0, 0, 1, 0, 0);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL brst_valid: got %b want 0", valid); end
        tests++; if (pc_out !== 32'h100 || inst !== word(32'h100)) begin fails++; $display("FAIL brst_held: got pc=%h inst=%h want pc=100", pc_out, inst); end
        run_fetch(32'h200, "brst");
        tick();
    endtask

    task automatic test_wrap_reset();
        set_in(0, 0, 0, 1, 32'hFFFFFFFC);
        tick();
        run_fetch(32'hFFFFFFFC, "wrap");
        tick();
        set_in(0, 0, 0, 0, 0);
        tests++; if (mem_rd !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL wrap_next: got rd=%b addr=%h want addr=0", mem_rd, addr); end
        tick();
        set_in(0, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0);
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL mid_rst_rd: got %b want 0", mem_rd); end
        tick();
        set_in(0, 0, 0, 0, 0);
        tests++; if (valid !== 1'b0 || pc_out !== 32'h0 || inst !== 32'h0) begin fails++; $display("FAIL mid_rst_out: got v=%b pc=%h inst=%h want all 0", valid, pc_out, inst); end
        tests++; if (mem_rd !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL mid_rst_addr: got %h want 0", addr); end
    endtask

    // Model: requests walk exp_pc..exp_pc+3; each delivery carries exp_pc and the word there.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] hold_pc = 32'h0, hold_inst = 32'h0;
        logic        pv = 1'b0, ps = 1'b0, pb = 1'b0;
        int          nacc = 0, nout = 0;
        for (int i = 0; i < 3000; i++) begin
            set_in(0, ($urandom % 10) < 3, ($urandom % 10) < 4, ($urandom % 40) == 0,
                   (($urandom % 4) == 0) ? 32'hFFFFFFF0 + 32'($urandom % 16) : $urandom);
            if (br) begin
                tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL rnd_br_rd i%0d: got %b want 0", i, mem_rd); end
            end
            if (pv && !pb) begin
                tests++; if (valid !== ps) begin fails++; $display("FAIL rnd_stall_valid i%0d: got %b want %b", i, valid, ps); end
            end
            if (pv && valid) begin
                tests++; if (pc_out !== hold_pc || inst !== hold_inst) begin fails++; $display("FAIL rnd_hold i%0d: got pc=%h inst=%h want pc=%h inst=%h", i, pc_out, inst, hold_pc, hold_inst); end
            end
            if (valid && !pv) begin
                tests++; if (pc_out !== exp_pc || inst !== word(exp_pc)) begin fails++; $display("FAIL rnd_out i%0d: got pc=%h inst=%h want pc=%h inst=%h", i, pc_out, inst, exp_pc, word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                nout++;
            end
            if (mem_rd && !busy) begin
                tests++; if (addr !== exp_pc + 32'(nacc)) begin fails++; $display("FAIL rnd_addr i%0d: got %h want %h", i, addr, exp_pc + 32'(nacc)); end
                nacc = (nacc + 1) % 4;
            end
            if (br) begin
                exp_pc = tgt;
                nacc   = 0;
            end
            pv = valid; ps = stall; pb = br;
            hold_pc = pc_out; hold_inst = inst;
            tick();
        end
        tests++; if (nout < 50) begin fails++; $display("FAIL rnd_progress: got %0d deliveries want >= 50", nout); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; busy = 1'b0; tgt = '0; rdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_busy();
        test_redirect();
        test_redirect_stall();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; directly upstream of the IF/ID pipeline register.
- Holds the PC and assembles each 32-bit instruction from four byte reads over the byte-wide memory port, little-endian.
- Presents pc/inst/valid to IF/ID; honours the pipeline stall and branch redirects from EX.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INST_W, 32, instruction width; fixed at 4 bytes.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  downstream cannot accept; hold the presented instruction.
- br_taken_i  input  1  redirect request from EX, one-cycle pulse.
- br_target_i  input  ADDR_W  redirect target PC.
- mem_busy_i  input  1  memory port not accepting requests this cycle.
- mem_rdata_i  input  8  read byte; valid the cycle after an accepted request.
- mem_rd_o  output  1  read request (combinational).
- mem_addr_o  output  ADDR_W  byte address of request (combinational).
- if_pc_o  output  ADDR_W  PC of presented instruction (registered).
- if_inst_o  output  INST_W  presented instruction (registered).
- if_valid_o  output  1  if_pc_o/if_inst_o hold a live instruction (registered).

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: pc <= RESET_PC, state <= FETCH, req_cnt <= 0, pend <= 0, if_pc_o <= 0, if_inst_o <= 0, if_valid_o <= 0. mem_rd_o is 0 while rst is high.
- States: FETCH, WAIT_LAST, OUT.
- FETCH:
  - mem_rd_o = 1 and mem_addr_o = pc + req_cnt (mod 2^ADDR_W).
  - A request is accepted when mem_rd_o = 1 and mem_busy_i = 0.
  - On accept: req_cnt increments. After the request with req_cnt = 3 is accepted, go to WAIT_LAST with req_cnt = 0.
  - If mem_busy_i = 1, hold the address and re-request next cycle.
- Byte capture: an accept in cycle N sets pend = 1 and pend_idx = req_cnt. In cycle N+1, mem_rdata_i is written into byte pend_idx of the assembly buffer (byte 0 = bits 7:0). Capture is independent of state and of mem_busy_i in N+1.
- WAIT_LAST (byte 3 is on mem_rdata_i this cycle):
  - if_inst_o <= {mem_rdata_i, buf[23:0]}, if_pc_o <= pc, if_valid_o <= 1.
  - pc <= pc + 4 (wraps); go to OUT.
  - mem_rd_o = 0.
- OUT:
  - mem_rd_o = 0; outputs held.
  - If stall_i = 0, the instruction is consumed this cycle: if_valid_o <= 0, go to FETCH.
  - If stall_i = 1, stay in OUT; outputs unchanged for any number of cycles.
- Latency with no busy/stall: first request in cycle 0, if_valid_o high in cycle 5, next request in cycle 6 (6-cycle throughput).
- Redirect (br_taken_i = 1) has priority over everything except rst:
  - mem_rd_o forced 0 that cycle.
  - pc <= br_target_i, state <= FETCH, req_cnt <= 0, pend <= 0, if_valid_o <= 0.
  - Any in-flight byte is discarded. if_pc_o/if_inst_o keep old values but are marked invalid.
- Redirect overrides stall_i and can arrive in any state. No alignment check on the target; bytes are fetched at target..target+3.
- if_pc_o/if_inst_o hold their last value while if_valid_o = 0.
- rst mid-fetch: all state returns to the reset values next edge; the byte of an outstanding request is ignored.

Test Plan:
- Reset then run, mem bytes at 0..3 = 13,05,10,00, mem_busy_i=0, stall_i=0 -> mem_addr_o 0,1,2,3 in cycles 0-3; cycle 5: if_valid_o=1, if_pc_o=0, if_inst_o=32'h00100513; next request addr 4 in cycle 6.
- mem_busy_i=1 during cycles 1-2 of fetch at pc 8 -> mem_addr_o stays 9 for 3 cycles; final if_inst_o still matches bytes 8..11; if_valid_o rises 2 cycles later than nominal.
- stall_i=1 for 4 cycles once if_valid_o rises at pc 4 -> if_valid_o, if_pc_o=4 and if_inst_o held 4 cycles; no mem_rd_o; fetch of addr 8 begins the cycle after the consume.
- br_taken_i pulse with target 32'h100 while req_cnt=2 at pc 0x10 -> mem_rd_o=0 that cycle, next requests 0x100..0x103; byte from addr 0x11 not merged; output if_pc_o=0x100 with the bytes from 0x100.
- br_taken_i with stall_i=1 in OUT -> if_valid_o drops next cycle; fetch restarts at target.
- pc=32'hFFFFFFFC fetch completes -> next fetch address 0 (wrap); rst asserted mid-fetch -> next cycle pc=RESET_PC, if_valid_o=0, if_inst_o=0.
